// File: rtl/offset_mix_sequencer_if.sv
// Offset-in / duty-out bundle between the offset generators, the mix sequencer and the PWM stage.
interface offset_mix_sequencer_if;
  logic        frame_start;
  logic        arm;
  logic [31:0] thr_offsets;
  logic [31:0] pitch_offsets;
  logic [31:0] roll_offsets;
  logic [31:0] yaw_offsets;
  logic [7:0]  motor_1_duty;
  logic [7:0]  motor_2_duty;
  logic [7:0]  motor_3_duty;
  logic [7:0]  motor_4_duty;
  logic [3:0]  sat_flags;
  logic        duty_valid;
  logic        busy;
  logic        frame_overrun;

  modport master (
    output frame_start, arm, thr_offsets, pitch_offsets, roll_offsets, yaw_offsets,
    input  motor_1_duty, motor_2_duty, motor_3_duty, motor_4_duty,
    input  sat_flags, duty_valid, busy, frame_overrun
  );

  modport slave (
    input  frame_start, arm, thr_offsets, pitch_offsets, roll_offsets, yaw_offsets,
    output motor_1_duty, motor_2_duty, motor_3_duty, motor_4_duty,
    output sat_flags, duty_valid, busy, frame_overrun
  );
endinterface

// File: rtl/offset_mix_sequencer.sv
// Mixes four offset generators into clamped per-motor duties through one shared accumulator.
// 21 cycles capture-to-valid; one frame request may queue while busy, a further one is dropped and flagged.
module offset_mix_sequencer #(
  parameter int CENTER   = 20,
  parameter int DUTY_MIN = 10,
  parameter int DUTY_MAX = 100
) (
  input logic                  clk,
  input logic                  rst_n,
  offset_mix_sequencer_if.slave bus
);

  localparam logic signed [10:0] OFS_S   = 11'(3 * CENTER);
  localparam logic signed [10:0] MIN_S   = 11'(DUTY_MIN);
  localparam logic signed [10:0] MAX_S   = 11'(DUTY_MAX);
  localparam logic [7:0]         MIN_B   = 8'(DUTY_MIN);
  localparam logic [7:0]         MAX_B   = 8'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       thr_q, thr_d, pitch_q, pitch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [9:0]        acc_q, acc_d;
  logic [1:0]        m_q, m_d, t_q, t_d;
  logic [3:0][7:0]   duty_q, duty_d;
  logic [3:0]        sat_q, sat_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;

  logic [31:0]       sel;
  logic [7:0]        term;
  logic signed [10:0] r;
  logic              capture;

  always_comb begin
    unique case (t_q)
      2'd0:    sel = thr_q;
      2'd1:    sel = pitch_q;
      2'd2:    sel = roll_q;
      default: sel = yaw_q;
    endcase
    term = sel[{m_q, 3'b000} +: 8];
    r    = $signed({1'b0, acc_q}) - OFS_S;
  end

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    pitch_d = pitch_q;
    roll_d  = roll_q;
    yaw_d   = yaw_q;
    acc_d   = acc_q;
    m_d     = m_q;
    t_d     = t_q;
    duty_d  = duty_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    pend_d  = pend_q;
    ovr_d   = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          capture = 1'b1;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM, WRITE: begin
        // One request may wait for the current pass; anything beyond that is lost.
        if (bus.frame_start) begin
          if (pend_q) ovr_d  = 1'b1;
          else        pend_d = 1'b1;
        end
        if (state_q == ACCUM) begin
          acc_d = acc_q + {2'b00, term};
          t_d   = t_q + 2'd1;
          if (t_q == 2'd3) state_d = WRITE;
        end else begin
          if (!bus.arm) begin
            duty_d[m_q] = MIN_B;
            sat_d[m_q]  = 1'b0;
          end else if (r < MIN_S) begin
            duty_d[m_q] = MIN_B;
            sat_d[m_q]  = 1'b1;
          end else if (r > MAX_S) begin
            duty_d[m_q] = MAX_B;
            sat_d[m_q]  = 1'b1;
          end else begin
            duty_d[m_q] = r[7:0];
            sat_d[m_q]  = 1'b0;
          end
          acc_d = '0;
          t_d   = 2'd0;
          if (m_q == 2'd3) begin
            state_d = DONE;
          end else begin
            m_d     = m_q + 2'd1;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        valid_d = 1'b1;
        if (pend_q || bus.frame_start) begin
          // Pending and a fresh request collapse into one restart.
          ovr_d   = pend_q & bus.frame_start;
          pend_d  = 1'b0;
          capture = 1'b1;
          state_d = ACCUM;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      thr_d   = bus.thr_offsets;
      pitch_d = bus.pitch_offsets;
      roll_d  = bus.roll_offsets;
      yaw_d   = bus.yaw_offsets;
      acc_d   = '0;
      m_d     = 2'd0;
      t_d     = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      thr_q   <= '0;
      pitch_q <= '0;
      roll_q  <= '0;
      yaw_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      t_q     <= '0;
      duty_q  <= {4{MIN_B}};
      sat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      pitch_q <= pitch_d;
      roll_q  <= roll_d;
      yaw_q   <= yaw_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      t_q     <= t_d;
      duty_q  <= duty_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.motor_1_duty  = duty_q[0];
  assign bus.motor_2_duty  = duty_q[1];
  assign bus.motor_3_duty  = duty_q[2];
  assign bus.motor_4_duty  = duty_q[3];
  assign bus.sat_flags     = sat_q;
  assign bus.duty_valid    = valid_q;
  assign bus.busy          = busy_q;
  assign bus.frame_overrun = ovr_q;

endmodule
